// File: rtl/gray_step_decoder.sv
// rtl/gray_step_decoder.sv - reflected-Gray to binary decoder with step classification
//
// Purpose: converts each accepted Gray word to binary, classifies the step from
// the previously accepted word as hold / +1 / -1 / illegal, counts illegal
// steps (saturating) and tracks lock with an EMPTY/LOCKED/FAULT state machine.
//
// Ports:
//   clk        single clock, rising edge
//   rst        synchronous active-high reset
//   gray_in    sampled Gray code word (WIDTH bits)
//   valid_in   qualifies gray_in
//   err_clr    synchronous clear of err_count
//   bin_out    registered binary of last accepted word
//   bin_valid  one-cycle strobe: new bin_out
//   dir_up     one-cycle strobe: +1 step
//   dir_down   one-cycle strobe: -1 step
//   step_err   one-cycle strobe: illegal step
//   err_count  saturating count of illegal steps (ERR_W bits)
//   locked     1 while the state machine is in LOCKED
module gray_step_decoder #(
  parameter int WIDTH = 4,
  parameter int ERR_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] gray_in,
  input  logic             valid_in,
  input  logic             err_clr,
  output logic [WIDTH-1:0] bin_out,
  output logic             bin_valid,
  output logic             dir_up,
  output logic             dir_down,
  output logic             step_err,
  output logic [ERR_W-1:0] err_count,
  output logic             locked
);

  typedef enum logic [1:0] {
    EMPTY  = 2'd0,
    LOCKED = 2'd1,
    FAULT  = 2'd2
  } state_t;

  localparam logic [ERR_W-1:0] ERR_MAX = '1;
  localparam logic [WIDTH-1:0] STEP_UP = WIDTH'(1);
  localparam logic [WIDTH-1:0] STEP_DN = '1;

  state_t           state, state_n;
  // In FAULT: set after the first good step of a recovery pair.
  logic             good, good_n;
  logic [WIDTH-1:0] bin_new, bin_n, diff;
  logic             bin_valid_n, dir_up_n, dir_down_n, step_err_n;
  logic [ERR_W-1:0] err_count_n;

  // Binary bit i is the XOR of all Gray bits from i upward.
  always_comb begin
    bin_new = '0;
    for (int i = 0; i < WIDTH; i++) begin
      bin_new[i] = ^(gray_in >> i);
    end
  end

  // bin_out always holds the previously accepted word, so it serves as b_prev.
  assign diff = bin_new - bin_out;

  always_comb begin
    state_n     = state;
    good_n      = good;
    bin_n       = bin_out;
    bin_valid_n = 1'b0;
    dir_up_n    = 1'b0;
    dir_down_n  = 1'b0;
    step_err_n  = 1'b0;

    if (valid_in) begin
      bin_n       = bin_new;
      bin_valid_n = 1'b1;
      if (state == EMPTY) begin
        state_n = LOCKED;
        good_n  = 1'b0;
      end else begin
        if (diff == STEP_UP) begin
          dir_up_n = 1'b1;
        end else if (diff == STEP_DN) begin
          dir_down_n = 1'b1;
        end else if (diff != '0) begin
          step_err_n = 1'b1;
        end

        if (step_err_n) begin
          state_n = FAULT;
          good_n  = 1'b0;
        end else if (state == FAULT && (dir_up_n || dir_down_n)) begin
          if (good) begin
            state_n = LOCKED;
            good_n  = 1'b0;
          end else begin
            good_n = 1'b1;
          end
        end
      end
    end

    // A clear coinciding with an error leaves that error counted.
    err_count_n = err_count;
    if (err_clr) begin
      err_count_n = step_err_n ? ERR_W'(1) : '0;
    end else if (step_err_n && err_count != ERR_MAX) begin
      err_count_n = err_count + ERR_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= EMPTY;
      good      <= 1'b0;
      bin_out   <= '0;
      bin_valid <= 1'b0;
      dir_up    <= 1'b0;
      dir_down  <= 1'b0;
      step_err  <= 1'b0;
      err_count <= '0;
    end else begin
      state     <= state_n;
      good      <= good_n;
      bin_out   <= bin_n;
      bin_valid <= bin_valid_n;
      dir_up    <= dir_up_n;
      dir_down  <= dir_down_n;
      step_err  <= step_err_n;
      err_count <= err_count_n;
    end
  end

  assign locked = (state == LOCKED);

endmodule

// File: tb/tb_gray_step_decoder.sv
// tb/tb_gray_step_decoder.sv - table-driven and randomized bench for gray_step_decoder
module tb_gray_step_decoder;

  localparam int W  = 4;
  localparam int EW = 2;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic [W-1:0]  gray_in = '0;
  logic          valid_in = 1'b0;
  logic          err_clr = 1'b0;
  logic [W-1:0]  bin_out;
  logic          bin_valid, dir_up, dir_down, step_err, locked;
  logic [EW-1:0] err_count;

  gray_step_decoder #(.WIDTH(W), .ERR_W(EW)) dut (
    .clk(clk), .rst(rst), .gray_in(gray_in), .valid_in(valid_in), .err_clr(err_clr),
    .bin_out(bin_out), .bin_valid(bin_valid), .dir_up(dir_up), .dir_down(dir_down),
    .step_err(step_err), .err_count(err_count), .locked(locked)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model: inverse Gray via table of n -> n^(n>>1).
  int inv [16];
  bit m_have, m_fault;
  int m_prev, m_good, m_err;
  int e_bin, e_bv, e_up, e_dn, e_er, e_lk;

  typedef struct {
    bit r; bit v; logic [3:0] g; bit c;
    int eb; bit ev; bit eu; bit ed; bit ee; int ec; bit el;
  } vec_t;

  vec_t tbl [$];

  function automatic logic [10:0] pack(int b, bit v, bit u, bit d, bit e, int c, bit l);
    logic [3:0] b4 = b[3:0];
    logic [1:0] c2 = c[1:0];
    return {b4, v, u, d, e, c2, l};
  endfunction

  function automatic logic [10:0] dut_vec();
    return {bin_out, bin_valid, dir_up, dir_down, step_err, err_count, locked};
  endfunction

  task automatic model_step(bit r, bit v, logic [3:0] g, bit c);
    int b, d;
    e_bv = 0; e_up = 0; e_dn = 0; e_er = 0;
    if (r) begin
      m_have = 0; m_prev = 0; m_fault = 0; m_good = 0; m_err = 0;
    end else begin
      if (v) begin
        b = inv[g];
        e_bv = 1;
        if (!m_have) begin
          m_have = 1; m_fault = 0; m_good = 0;
        end else begin
          d = (b - m_prev + 16) % 16;
          if (d == 1) e_up = 1;
          else if (d == 15) e_dn = 1;
          else if (d != 0) e_er = 1;
          if (e_er) begin
            m_fault = 1; m_good = 0;
          end else if (m_fault && (e_up || e_dn)) begin
            m_good++;
            if (m_good == 2) begin m_fault = 0; m_good = 0; end
          end
        end
        m_prev = b;
      end
      if (c) m_err = e_er;
      else if (e_er && m_err < (1 << EW) - 1) m_err++;
    end
    e_bin = m_prev;
    e_lk  = m_have && !m_fault;
  endtask

  task automatic drive(bit r, bit v, logic [3:0] g, bit c);
    rst = r; valid_in = v; gray_in = g; err_clr = c;
    @(posedge clk);
    #1;
    model_step(r, v, g, c);
  endtask

  task automatic check(string name, logic [10:0] act, logic [10:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got bin=%0d bv=%b up=%b dn=%b err=%b cnt=%0d lk=%b, expected bin=%0d bv=%b up=%b dn=%b err=%b cnt=%0d lk=%b",
               name, act[10:7], act[6], act[5], act[4], act[3], act[2:1], act[0],
               exp[10:7], exp[6], exp[5], exp[4], exp[3], exp[2:1], exp[0]);
    end
  endtask

  task automatic add(bit r, bit v, logic [3:0] g, bit c,
                     int eb, bit ev, bit eu, bit ed, bit ee, int ec, bit el);
    vec_t t;
    t.r = r; t.v = v; t.g = g; t.c = c;
    t.eb = eb; t.ev = ev; t.eu = eu; t.ed = ed; t.ee = ee; t.ec = ec; t.el = el;
    tbl.push_back(t);
  endtask

  initial begin
    for (int n = 0; n < 16; n++) inv[n ^ (n >> 1)] = n;

    //  r  v  gray     c  bin bv up dn er cnt lk
    add(1, 0, 4'b0000, 0, 0,  0, 0, 0, 0, 0, 0);  // reset state
    add(0, 1, 4'b0000, 0, 0,  1, 0, 0, 0, 0, 1);  // count up 0..3
    add(0, 1, 4'b0001, 0, 1,  1, 1, 0, 0, 0, 1);
    add(0, 1, 4'b0011, 0, 2,  1, 1, 0, 0, 0, 1);
    add(0, 1, 4'b0010, 0, 3,  1, 1, 0, 0, 0, 1);
    add(1, 0, 4'b0000, 0, 0,  0, 0, 0, 0, 0, 0);  // wrap
    add(0, 1, 4'b1000, 0, 15, 1, 0, 0, 0, 0, 1);
    add(0, 1, 4'b0000, 0, 0,  1, 1, 0, 0, 0, 1);
    add(0, 1, 4'b1000, 0, 15, 1, 0, 1, 0, 0, 1);
    add(1, 0, 4'b0000, 0, 0,  0, 0, 0, 0, 0, 0);  // error and recovery
    add(0, 1, 4'b0000, 0, 0,  1, 0, 0, 0, 0, 1);
    add(0, 1, 4'b0100, 0, 7,  1, 0, 0, 1, 1, 0);
    add(0, 1, 4'b0101, 0, 6,  1, 0, 1, 0, 1, 0);
    add(0, 1, 4'b0111, 0, 5,  1, 0, 1, 0, 1, 1);
    add(0, 0, 4'b0000, 1, 5,  0, 0, 0, 0, 0, 1);  // clear, then saturation
    add(0, 1, 4'b0000, 0, 0,  1, 0, 0, 1, 1, 0);
    add(0, 1, 4'b0111, 0, 5,  1, 0, 0, 1, 2, 0);
    add(0, 1, 4'b0000, 0, 0,  1, 0, 0, 1, 3, 0);
    add(0, 1, 4'b0111, 0, 5,  1, 0, 0, 1, 3, 0);
    add(0, 1, 4'b0000, 0, 0,  1, 0, 0, 1, 3, 0);
    add(0, 1, 4'b0111, 1, 5,  1, 0, 0, 1, 1, 0);  // clear with error -> 1
    add(1, 0, 4'b0000, 0, 0,  0, 0, 0, 0, 0, 0);  // hold and gaps
    add(0, 1, 4'b0001, 0, 1,  1, 0, 0, 0, 0, 1);
    add(0, 0, 4'b1111, 0, 1,  0, 0, 0, 0, 0, 1);
    add(0, 0, 4'b0110, 0, 1,  0, 0, 0, 0, 0, 1);
    add(0, 0, 4'b1010, 0, 1,  0, 0, 0, 0, 0, 1);
    add(0, 1, 4'b0001, 0, 1,  1, 0, 0, 0, 0, 1);
    add(0, 1, 4'b0011, 0, 2,  1, 1, 0, 0, 0, 1);
    add(0, 1, 4'b0000, 0, 0,  1, 0, 0, 1, 1, 0);  // into FAULT, cnt 2
    add(0, 1, 4'b0011, 0, 2,  1, 0, 0, 1, 2, 0);
    add(1, 1, 4'b0001, 1, 0,  0, 0, 0, 0, 0, 0);  // reset overrides valid/clr
    add(0, 1, 4'b0110, 0, 4,  1, 0, 0, 0, 0, 1);
    add(0, 1, 4'b0000, 0, 0,  1, 0, 0, 1, 1, 0);  // hold inside recovery
    add(0, 1, 4'b0001, 0, 1,  1, 1, 0, 0, 1, 0);
    add(0, 1, 4'b0001, 0, 1,  1, 0, 0, 0, 1, 0);
    add(0, 1, 4'b0011, 0, 2,  1, 1, 0, 0, 1, 1);
    add(0, 1, 4'b0000, 0, 0,  1, 0, 0, 1, 2, 0);  // error resets recovery
    add(0, 1, 4'b0001, 0, 1,  1, 1, 0, 0, 2, 0);
    add(0, 1, 4'b0100, 0, 7,  1, 0, 0, 1, 3, 0);
    add(0, 1, 4'b0101, 0, 6,  1, 0, 1, 0, 3, 0);
    add(0, 1, 4'b0111, 0, 5,  1, 0, 1, 0, 3, 1);

    foreach (tbl[i]) begin
      drive(tbl[i].r, tbl[i].v, tbl[i].g, tbl[i].c);
      check($sformatf("vec%0d", i), dut_vec(),
            pack(tbl[i].eb, tbl[i].ev, tbl[i].eu, tbl[i].ed, tbl[i].ee, tbl[i].ec, tbl[i].el));
    end

    // Random phase: mostly neighbouring codes so recovery paths are exercised.
    for (int k = 0; k < 600; k++) begin
      bit r, v, c;
      int b, sel;
      logic [3:0] g;
      r = ($urandom_range(0, 39) == 0);
      v = ($urandom_range(0, 3) != 0);
      c = ($urandom_range(0, 15) == 0);
      sel = $urandom_range(0, 9);
      if (sel < 4)      b = (m_prev + 1) % 16;
      else if (sel < 7) b = (m_prev + 15) % 16;
      else if (sel < 8) b = m_prev;
      else              b = $urandom_range(0, 15);
      g = 4'(b ^ (b >> 1));
      drive(r, v, g, c);
      check($sformatf("rand%0d", k), dut_vec(),
            pack(e_bin, e_bv[0], e_up[0], e_dn[0], e_er[0], m_err, e_lk[0]));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
